// File: rtl/ws2812_pkg.sv
// Shared WS2812 link constants and types for the matrix transmitter and the loopback receiver.
package ws2812_pkg;
   localparam int BIT_CYCLES     = 15;
   localparam int BITS_PER_PIXEL = 24;
   localparam int NUM_PIXELS     = 64;
   localparam int T0H_CYCLES     = 5;
   localparam int T1H_CYCLES     = 10;
   localparam int RESET_CYCLES   = 600;
   localparam int PIX_IDX_W      = $clog2(NUM_PIXELS);
   localparam int FRAME_CNT_W    = 5;

   typedef logic [23:0] pixel_t;

   typedef enum logic [1:0] {WAIT_GAP, IDLE, HIGH, LOW} rx_state_t;
endpackage

// File: rtl/ws2812_if.sv
// Receiver result bus: pixel strobes plus frame/error/overflow status.
interface ws2812_if;
   import ws2812_pkg::*;

   logic                   pixel_valid;
   pixel_t                 pixel_data;
   logic [PIX_IDX_W-1:0]   pixel_index;
   logic                   frame_done;
   logic [FRAME_CNT_W-1:0] frame_count;
   logic                   error;
   logic                   overflow;

   modport master (output pixel_valid, pixel_data, pixel_index, frame_done,
                   frame_count, error, overflow);
   modport slave  (input  pixel_valid, pixel_data, pixel_index, frame_done,
                   frame_count, error, overflow);
endinterface

// File: rtl/input_sync.sv
// Two-flop synchronizer for the asynchronous data line, with edge detect on the synced level.
module input_sync (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic din_s,
   output logic rise,
   output logic fall
);
   logic meta;
   logic din_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta  <= 1'b0;
         din_s <= 1'b0;
         din_d <= 1'b0;
      end else begin
         meta  <= din;
         din_s <= meta;
         din_d <= din_s;
      end
   end

   assign rise = din_s & ~din_d;
   assign fall = ~din_s & din_d;
endmodule

// File: rtl/ws2812_receiver.sv
// WS2812 stream decoder: classifies bits by high width, assembles GRB pixels, detects latch gaps.
module ws2812_receiver #(
   parameter int NUM_PIXELS     = ws2812_pkg::NUM_PIXELS,
   parameter int BITS_PER_PIXEL = ws2812_pkg::BITS_PER_PIXEL,
   parameter int T1_THRESH      = 7,
   parameter int MIN_HIGH       = 2,
   parameter int MAX_HIGH       = 20,
   parameter int RESET_CYCLES   = ws2812_pkg::RESET_CYCLES
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     din,
   ws2812_if.master rx
);
   import ws2812_pkg::*;

   localparam int HW = $clog2(MAX_HIGH + 1);
   localparam int LW = $clog2(RESET_CYCLES + 1);
   localparam int BW = $clog2(BITS_PER_PIXEL);
   localparam int PW = $clog2(NUM_PIXELS + 1);
   localparam int IW = $clog2(NUM_PIXELS);

   localparam logic [HW-1:0] T1_V     = HW'(T1_THRESH);
   localparam logic [HW-1:0] MIN_V    = HW'(MIN_HIGH);
   localparam logic [HW-1:0] HLAST_V  = HW'(MAX_HIGH - 1);
   localparam logic [LW-1:0] LLAST_V  = LW'(RESET_CYCLES - 1);
   localparam logic [BW-1:0] BLAST_V  = BW'(BITS_PER_PIXEL - 1);
   localparam logic [PW-1:0] NPIX_V   = PW'(NUM_PIXELS);

   logic din_s, rise, fall;

   input_sync u_sync (
      .clk   (clk),
      .rst   (rst),
      .din   (din),
      .din_s (din_s),
      .rise  (rise),
      .fall  (fall)
   );

   rx_state_t       state, state_n;
   logic [HW-1:0]   high_cnt, high_n;
   logic [LW-1:0]   low_cnt, low_n;
   logic [BW-1:0]   bit_cnt, bit_n;
   logic [PW-1:0]   pix_cnt, pix_n;
   pixel_t          sreg, sreg_n, shifted;

   // Decode-stage strobes; the output stage below re-registers them.
   logic            pix_stb_q, pix_stb_d;
   pixel_t          pix_word_q, pix_word_d;
   logic [IW-1:0]   pix_idx_q, pix_idx_d;
   logic            frm_stb_q, frm_stb_d;
   logic            err_stb_q, err_stb_d;
   logic            ovf_set_q, ovf_set_d;
   logic            ovf_clr_q, ovf_clr_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= WAIT_GAP;
         high_cnt   <= '0;
         low_cnt    <= '0;
         bit_cnt    <= '0;
         pix_cnt    <= '0;
         sreg       <= '0;
         pix_stb_q  <= 1'b0;
         pix_word_q <= '0;
         pix_idx_q  <= '0;
         frm_stb_q  <= 1'b0;
         err_stb_q  <= 1'b0;
         ovf_set_q  <= 1'b0;
         ovf_clr_q  <= 1'b0;
      end else begin
         state      <= state_n;
         high_cnt   <= high_n;
         low_cnt    <= low_n;
         bit_cnt    <= bit_n;
         pix_cnt    <= pix_n;
         sreg       <= sreg_n;
         pix_stb_q  <= pix_stb_d;
         pix_word_q <= pix_word_d;
         pix_idx_q  <= pix_idx_d;
         frm_stb_q  <= frm_stb_d;
         err_stb_q  <= err_stb_d;
         ovf_set_q  <= ovf_set_d;
         ovf_clr_q  <= ovf_clr_d;
      end
   end

   always_comb begin
      state_n    = state;
      high_n     = high_cnt;
      low_n      = low_cnt;
      bit_n      = bit_cnt;
      pix_n      = pix_cnt;
      sreg_n     = sreg;
      pix_stb_d  = 1'b0;
      pix_word_d = pix_word_q;
      pix_idx_d  = pix_idx_q;
      frm_stb_d  = 1'b0;
      err_stb_d  = 1'b0;
      ovf_set_d  = 1'b0;
      ovf_clr_d  = 1'b0;
      shifted    = {sreg[22:0], (high_cnt >= T1_V)};

      case (state)
         WAIT_GAP: begin
            if (din_s) begin
               low_n = '0;
            end else if (low_cnt == LLAST_V) begin
               state_n = IDLE;
               low_n   = '0;
            end else begin
               low_n = low_cnt + 1'b1;
            end
         end
         IDLE: begin
            if (rise) begin
               state_n = HIGH;
               high_n  = HW'(1);
               bit_n   = '0;
               pix_n   = '0;
            end
         end
         HIGH: begin
            if (fall) begin
               if (high_cnt < MIN_V) begin
                  err_stb_d = 1'b1;
                  state_n   = WAIT_GAP;
                  low_n     = LW'(1);
               end else begin
                  sreg_n  = shifted;
                  state_n = LOW;
                  low_n   = LW'(1);
                  if (bit_cnt == BLAST_V) begin
                     bit_n = '0;
                     if (pix_cnt < NPIX_V) begin
                        pix_stb_d  = 1'b1;
                        pix_word_d = shifted;
                        pix_idx_d  = pix_cnt[IW-1:0];
                        pix_n      = pix_cnt + 1'b1;
                     end else begin
                        ovf_set_d = 1'b1;
                     end
                  end else begin
                     bit_n = bit_cnt + 1'b1;
                  end
               end
            end else if (high_cnt == HLAST_V) begin
               // Stuck-high line: drop the partial pixel and wait for a clean gap.
               err_stb_d = 1'b1;
               state_n   = WAIT_GAP;
               low_n     = '0;
            end else begin
               high_n = high_cnt + 1'b1;
            end
         end
         LOW: begin
            if (rise) begin
               state_n = HIGH;
               high_n  = HW'(1);
            end else if (low_cnt == LLAST_V) begin
               err_stb_d = (bit_cnt != '0);
               frm_stb_d = (pix_cnt != '0);
               ovf_clr_d = 1'b1;
               state_n   = IDLE;
               low_n     = '0;
            end else begin
               low_n = low_cnt + 1'b1;
            end
         end
         default: state_n = WAIT_GAP;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx.pixel_valid <= 1'b0;
         rx.pixel_data  <= '0;
         rx.pixel_index <= '0;
         rx.frame_done  <= 1'b0;
         rx.frame_count <= '0;
         rx.error       <= 1'b0;
         rx.overflow    <= 1'b0;
      end else begin
         rx.pixel_valid <= pix_stb_q;
         rx.frame_done  <= frm_stb_q;
         rx.error       <= err_stb_q;
         if (pix_stb_q) begin
            rx.pixel_data  <= pix_word_q;
            rx.pixel_index <= pix_idx_q;
         end
         if (frm_stb_q)
            rx.frame_count <= rx.frame_count + 1'b1;
         if (ovf_clr_q)
            rx.overflow <= 1'b0;
         else if (ovf_set_q)
            rx.overflow <= 1'b1;
      end
   end
endmodule
